// File: rtl/bsg_mem_1rw_sync_mask_write_byte_arbiter_if.sv
// Requester-side bus of the shared 1rw byte-masked SRAM arbiter: packed per-requester
// request fields, one-hot accept (yumi) and one-hot read-response valid with shared data.
interface bsg_mem_1rw_sync_mask_write_byte_arbiter_if
  #(parameter int els_p        = 512
   ,parameter int data_width_p = 64
   ,parameter int num_req_p    = 2
   ,localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
   ,localparam int mask_width_lp = data_width_p >> 3
   );

  logic [num_req_p-1:0]               req_v;
  logic [num_req_p-1:0]               req_w;
  logic [num_req_p*addr_width_lp-1:0] req_addr;
  logic [num_req_p*data_width_p-1:0]  req_data;
  logic [num_req_p*mask_width_lp-1:0] req_mask;
  logic [num_req_p-1:0]               req_yumi;
  logic [num_req_p-1:0]               resp_v;
  logic [data_width_p-1:0]            resp_data;

  modport master (output req_v, req_w, req_addr, req_data, req_mask
                 ,input  req_yumi, resp_v, resp_data);

  modport slave  (input  req_v, req_w, req_addr, req_data, req_mask
                 ,output req_yumi, resp_v, resp_data);

endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_arbiter.sv
// Round-robin sharing of one sync-read byte-masked SRAM; grant is combinational (same cycle as v),
// read data returns one cycle after grant and cannot be back-pressured; optional zero-fill after reset.
module bsg_mem_1rw_sync_mask_write_byte_arbiter
  #(parameter int els_p        = 512
   ,parameter int data_width_p = 64
   ,parameter int num_req_p    = 2
   ,parameter bit init_zero_p  = 1'b1
   ,localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
   ,localparam int mask_width_lp = data_width_p >> 3
   ,localparam int lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
   )
  (input  logic                     clk_i
  ,input  logic                     reset_n_i
  ,bsg_mem_1rw_sync_mask_write_byte_arbiter_if.slave req_if
  ,output logic                     init_done_o
  ,output logic                     mem_v_o
  ,output logic                     mem_w_o
  ,output logic [addr_width_lp-1:0] mem_addr_o
  ,output logic [data_width_p-1:0]  mem_data_o
  ,output logic [mask_width_lp-1:0] mem_mask_o
  ,input  logic [data_width_p-1:0]  mem_data_i
  );

  typedef enum logic {e_init, e_ready} state_e;

  state_e                   state_q, state_d;
  logic [addr_width_lp-1:0] cnt_q, cnt_d;
  logic [lg_req_lp-1:0]     ptr_q, ptr_d;
  logic                     rd_v_q, rd_v_d;
  logic [lg_req_lp-1:0]     rd_id_q, rd_id_d;

  logic                     grant_v;
  logic [lg_req_lp-1:0]     grant_id;
  logic [lg_req_lp-1:0]     cand;
  logic                     sel_w;
  logic [addr_width_lp-1:0] sel_addr;
  logic [data_width_p-1:0]  sel_data;
  logic [mask_width_lp-1:0] sel_mask;

  // Search from the pointer outward; iterating downward lets the closest candidate win last.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      cand = lg_req_lp'((int'(ptr_q) + k) % num_req_p);
      if (req_if.req_v[cand]) begin
        grant_v  = 1'b1;
        grant_id = cand;
      end
    end
  end

  always_comb begin
    sel_w    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_id == lg_req_lp'(i)) begin
        sel_w    = req_if.req_w[i];
        sel_addr = req_if.req_addr[i*addr_width_lp +: addr_width_lp];
        sel_data = req_if.req_data[i*data_width_p +: data_width_p];
        sel_mask = req_if.req_mask[i*mask_width_lp +: mask_width_lp];
      end
    end
  end

  // Outputs are gated by reset_n_i so nothing reaches the memory or requesters while reset is held.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ptr_d           = ptr_q;
    rd_v_d          = 1'b0;
    rd_id_d         = rd_id_q;
    req_if.req_yumi = '0;
    mem_v_o         = 1'b0;
    mem_w_o         = 1'b0;
    mem_addr_o      = sel_addr;
    mem_data_o      = sel_data;
    mem_mask_o      = sel_mask;
    case (state_q)
      e_init: begin
        mem_v_o    = reset_n_i;
        mem_w_o    = 1'b1;
        mem_addr_o = cnt_q;
        mem_data_o = '0;
        mem_mask_o = '1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == addr_width_lp'(els_p - 1))
          state_d = e_ready;
      end
      e_ready: begin
        mem_w_o = sel_w;
        if (grant_v && reset_n_i) begin
          req_if.req_yumi[grant_id] = 1'b1;
          mem_v_o = 1'b1;
          ptr_d   = (grant_id == lg_req_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
          rd_v_d  = ~sel_w;
          rd_id_d = grant_id;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= init_zero_p ? e_init : e_ready;
      cnt_q   <= '0;
      ptr_q   <= '0;
      rd_v_q  <= 1'b0;
      rd_id_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rd_v_q  <= rd_v_d;
      rd_id_q <= rd_id_d;
    end
  end

  assign req_if.resp_v    = rd_v_q ? (num_req_p'(1) << rd_id_q) : '0;
  assign req_if.resp_data = mem_data_i;
  assign init_done_o      = (state_q == e_ready);

`ifndef SYNTHESIS
  a_width_bytes: assert property (@(posedge clk_i) (data_width_p % 8) == 0)
    else $error("data_width_p must be a multiple of 8");
  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(req_if.req_yumi))
    else $error("req_yumi not one-hot");
  a_resp_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(req_if.resp_v))
    else $error("resp_v not one-hot");
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_arbiter.sv
// Bench for the SRAM arbiter: directed scenarios plus random traffic, checked against a
// word-array memory model and a round-robin grant model; second instance covers no zero-fill.
module tb_bsg_mem_1rw_sync_mask_write_byte_arbiter;
  localparam int ELS = 16;
  localparam int AW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic init_done_a, init_done_b;
  logic mem_v_a, mem_w_a, mem_v_b, mem_w_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [63:0] mem_data_a, mem_data_b, mem_rdata_a, mem_rdata_b;
  logic [7:0] mem_mask_a, mem_mask_b;

  bsg_mem_1rw_sync_mask_write_byte_arbiter_if #(.els_p(ELS), .data_width_p(64), .num_req_p(2)) ifa ();
  bsg_mem_1rw_sync_mask_write_byte_arbiter_if #(.els_p(ELS), .data_width_p(64), .num_req_p(2)) ifb ();

  bsg_mem_1rw_sync_mask_write_byte_arbiter
    #(.els_p(ELS), .data_width_p(64), .num_req_p(2), .init_zero_p(1'b1)) dut_a
    (.clk_i(clk), .reset_n_i(rst_a_n), .req_if(ifa), .init_done_o(init_done_a)
    ,.mem_v_o(mem_v_a), .mem_w_o(mem_w_a), .mem_addr_o(mem_addr_a), .mem_data_o(mem_data_a)
    ,.mem_mask_o(mem_mask_a), .mem_data_i(mem_rdata_a));

  bsg_mem_1rw_sync_mask_write_byte_arbiter
    #(.els_p(ELS), .data_width_p(64), .num_req_p(2), .init_zero_p(1'b0)) dut_b
    (.clk_i(clk), .reset_n_i(rst_b_n), .req_if(ifb), .init_done_o(init_done_b)
    ,.mem_v_o(mem_v_b), .mem_w_o(mem_w_b), .mem_addr_o(mem_addr_b), .mem_data_o(mem_data_b)
    ,.mem_mask_o(mem_mask_b), .mem_data_i(mem_rdata_b));

  function automatic logic [63:0] patt(input int i);
    return {32'(32'hC0DE_0000 + i), 32'(32'h5A5A_0000 ^ i)};
  endfunction

  // Behavioural SRAMs: preloaded with a nonzero pattern, sync read, byte-masked write.
  logic [63:0] mem_a [ELS];
  logic [63:0] mem_b [ELS];
  logic loaded_a = 1'b0;
  logic loaded_b = 1'b0;

  always @(posedge clk) begin
    if (!loaded_a) begin
      for (int i = 0; i < ELS; i++) mem_a[i] <= patt(i);
      loaded_a <= 1'b1;
    end else if (mem_v_a) begin
      if (mem_w_a) begin
        for (int b = 0; b < 8; b++)
          if (mem_mask_a[b]) mem_a[mem_addr_a][8*b +: 8] <= mem_data_a[8*b +: 8];
      end else begin
        mem_rdata_a <= mem_a[mem_addr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (!loaded_b) begin
      for (int i = 0; i < ELS; i++) mem_b[i] <= patt(i);
      loaded_b <= 1'b1;
    end else if (mem_v_b) begin
      if (mem_w_b) begin
        for (int b = 0; b < 8; b++)
          if (mem_mask_b[b]) mem_b[mem_addr_b][8*b +: 8] <= mem_data_b[8*b +: 8];
      end else begin
        mem_rdata_b <= mem_b[mem_addr_b];
      end
    end
  end

  int n_pass, n_checks;
  int ptr;
  logic [63:0] ref_mem [ELS];
  logic [1:0]  exp_resp_v;
  logic [63:0] exp_resp_data;
  logic [1:0]  last_yumi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Called just after a negedge; returns at the following negedge.
  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [7:0] m0, input logic [7:0] m1);
    int g, c;
    logic gw;
    logic [3:0] ga;
    logic [63:0] gd;
    logic [7:0] gm;
    check("resp_v", ifa.resp_v, exp_resp_v);
    if (exp_resp_v != 2'b00) check("resp_data", ifa.resp_data, exp_resp_data);
    ifa.req_v = v; ifa.req_w = w; ifa.req_addr = {a1, a0};
    ifa.req_data = {d1, d0}; ifa.req_mask = {m1, m0};
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      c = (ptr + k) % 2;
      if (g < 0 && v[c[0]]) g = c;
    end
    last_yumi = ifa.req_yumi;
    check("yumi", ifa.req_yumi, (g < 0) ? 0 : (1 << g));
    check("mem_v", mem_v_a, g >= 0);
    exp_resp_v = 2'b00;
    if (g >= 0) begin
      gw = (g == 1) ? w[1] : w[0];
      ga = (g == 1) ? a1 : a0;
      gd = (g == 1) ? d1 : d0;
      gm = (g == 1) ? m1 : m0;
      check("mem_w", mem_w_a, gw);
      check("mem_addr", mem_addr_a, ga);
      check("mem_data", mem_data_a, gd);
      check("mem_mask", mem_mask_a, gm);
      if (gw) begin
        for (int b = 0; b < 8; b++) if (gm[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
      end else begin
        exp_resp_v    = (g == 1) ? 2'b10 : 2'b01;
        exp_resp_data = ref_mem[ga];
      end
      ptr = (g + 1) % 2;
    end
    @(negedge clk);
  endtask

  // Called at the negedge where reset has just been released; state is INIT with counter 0.
  task automatic init_phase(input int stop_at);
    ifa.req_v = 2'b11; ifa.req_w = 2'b00;
    for (int k = 0; k < ELS; k++) begin
      #1;
      check("init_done_low", init_done_a, 0);
      check("init_mem_v", mem_v_a, 1);
      check("init_mem_w", mem_w_a, 1);
      check("init_addr", mem_addr_a, k);
      check("init_data", mem_data_a, 0);
      check("init_mask", mem_mask_a, 8'hFF);
      check("init_yumi", ifa.req_yumi, 0);
      check("init_resp_v", ifa.resp_v, 0);
      if (k == stop_at) return;
      @(negedge clk);
    end
    ifa.req_v = 2'b00;
    #1;
    check("init_done_rise", init_done_a, 1);
    for (int i = 0; i < ELS; i++) ref_mem[i] = '0;
    ptr = 0;
    exp_resp_v = 2'b00;
  endtask

  initial begin
    n_pass = 0; n_checks = 0; ptr = 0;
    exp_resp_v = 2'b00; exp_resp_data = '0; last_yumi = 2'b00;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    ifa.req_v = 2'b11; ifa.req_w = 2'b00; ifa.req_addr = '0; ifa.req_data = '0; ifa.req_mask = '0;
    ifb.req_v = 2'b00; ifb.req_w = 2'b00; ifb.req_addr = '0; ifb.req_data = '0; ifb.req_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_yumi", ifa.req_yumi, 0);
    check("rst_resp_v", ifa.resp_v, 0);
    check("rst_mem_v", mem_v_a, 0);
    check("rst_init_done", init_done_a, 0);
    @(negedge clk);
    rst_a_n = 1'b1;

    // Reset mid-INIT at counter 7, then a full zero-fill from address 0.
    init_phase(7);
    rst_a_n = 1'b0;
    #1;
    check("midinit_mem_v", mem_v_a, 0);
    check("midinit_yumi", ifa.req_yumi, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    init_phase(-1);

    for (int a = 0; a < ELS; a++) step(2'b01, 2'b00, 4'(a), 4'd0, '0, '0, 8'h00, 8'h00);

    // Byte-masked merge.
    step(2'b01, 2'b01, 4'd5, 4'd0, 64'h1122334455667788, '0, 8'hFF, 8'h00);
    step(2'b01, 2'b01, 4'd5, 4'd0, 64'hAAAAAAAAAAAAAAAA, '0, 8'h0F, 8'h00);
    step(2'b01, 2'b00, 4'd5, 4'd0, '0, '0, 8'h00, 8'h00);
    check("bytemask", ifa.resp_data, 64'h11223344AAAAAAAA);

    // Pointer hold: req1 alone three times, then req0 wins the tie.
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 2'b00, 4'd0, 4'd5, '0, '0, 8'h00, 8'h00);
      check("hold_r1", last_yumi, 2'b10);
    end
    step(2'b11, 2'b00, 4'd1, 4'd2, '0, '0, 8'h00, 8'h00);
    check("hold_r0", last_yumi, 2'b01);

    // Contention: bring the pointer to 0, then alternating grants.
    step(2'b10, 2'b00, 4'd0, 4'd3, '0, '0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 2'b00, 4'd5, 4'd7, '0, '0, 8'h00, 8'h00);
      check("contend", last_yumi, (i % 2 == 1) ? 2'b10 : 2'b01);
    end

    // Read-after-write across requesters.
    step(2'b10, 2'b10, 4'd0, 4'd3, '0, 64'hCAFEF00D12345678, 8'h00, 8'hFF);
    step(2'b01, 2'b00, 4'd3, 4'd0, '0, '0, 8'h00, 8'h00);
    check("raw", ifa.resp_data, 64'hCAFEF00D12345678);

    for (int i = 0; i < 200; i++)
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
           ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
    step(2'b00, 2'b00, 4'd0, 4'd0, '0, '0, 8'h00, 8'h00);

    // Reset with a read pending on the bus: no response, pointer back to 0.
    step(2'b01, 2'b01, 4'd1, 4'd0, 64'h1, '0, 8'h01, 8'h00);
    ifa.req_v = 2'b01; ifa.req_w = 2'b00;
    rst_a_n = 1'b0;
    #1;
    check("rstop_yumi", ifa.req_yumi, 0);
    @(negedge clk);
    #1;
    check("rstop_resp_v", ifa.resp_v, 0);
    check("rstop_init_done", init_done_a, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    init_phase(-1);
    step(2'b11, 2'b00, 4'd2, 4'd4, '0, '0, 8'h00, 8'h00);
    check("rstop_ptr0", last_yumi, 2'b01);
    step(2'b00, 2'b00, 4'd0, 4'd0, '0, '0, 8'h00, 8'h00);

    // Instance without zero-fill.
    ifb.req_v = 2'b01; ifb.req_w = 2'b00; ifb.req_addr = {4'd0, 4'd2};
    #1;
    check("b_rst_init_done", init_done_b, 1);
    check("b_rst_yumi", ifb.req_yumi, 0);
    check("b_rst_mem_v", mem_v_b, 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    #1;
    check("b_first_yumi", ifb.req_yumi, 2'b01);
    check("b_first_mem_v", mem_v_b, 1);
    check("b_first_mem_w", mem_w_b, 0);
    check("b_first_addr", mem_addr_b, 2);
    @(negedge clk);
    ifb.req_v = 2'b00;
    #1;
    check("b_resp_v", ifb.resp_v, 2'b01);
    check("b_resp_data", ifb.resp_data, patt(2));
    check("b_idle_mem_v", mem_v_b, 0);
    @(negedge clk);
    ifb.req_v = 2'b10; ifb.req_w = 2'b10; ifb.req_addr = {4'd9, 4'd0};
    ifb.req_data = {64'h0123456789ABCDEF, 64'h0}; ifb.req_mask = {8'hFF, 8'h00};
    #1;
    check("b_wr_yumi", ifb.req_yumi, 2'b10);
    check("b_wr_mem_w", mem_v_b & mem_w_b, 1);
    check("b_wr_resp_v", ifb.resp_v, 0);
    @(negedge clk);
    ifb.req_v = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("b_idle_mem_v", mem_v_b, 0);
      check("b_idle_resp_v", ifb.resp_v, 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
